// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble),
// one input bit per clock. A start/busy/done handshake frames each
// conversion. bcd/ovf update only when a conversion completes, so a
// downstream display never shows a partial result. Values above the
// largest representable decimal saturate to all nines with ovf set.
module bin2bcd_seq #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int SR_W  = ACC_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  // Largest value that fits in DIGITS decimal digits (10^DIGITS - 1).
  function automatic longint unsigned max_decimal();
    longint unsigned p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    return p - 1;
  endfunction

  localparam longint unsigned MAX_VAL = max_decimal();

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_next_q, ovf_next_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  // Add 3 to every accumulator digit that is 5 or more; each digit wraps
  // within its own nibble, so no carry crosses into the next digit.
  function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] r;
    r = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) r[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  logic [ACC_W-1:0] acc_adj;
  assign acc_adj = add3(sr_q[SR_W-1 -: ACC_W]);

  // Next-state and datapath logic for the IDLE -> SHIFT -> FINISH sequence.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_next_d = ovf_next_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d       = {{ACC_W{1'b0}}, bin};
          cnt_d      = '0;
          ovf_next_d = (64'(bin) > MAX_VAL);
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // Correct digits first, then shift the whole {acc, bin} left by one;
        // the top accumulator bit falls off.
        sr_d  = {acc_adj[ACC_W-2:0], sr_q[BIN_WIDTH-1:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        bcd_d   = ovf_next_q ? {DIGITS{4'h9}} : sr_q[SR_W-1 -: ACC_W];
        ovf_d   = ovf_next_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset; reset aborts any
  // conversion in flight and clears the visible result.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_next_q <= ovf_next_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq. Each accepted conversion pushes its
// expected result and accept cycle into a scoreboard; a monitor pops and
// compares on every done pulse, including latency.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;

  bin2bcd_seq #(.BIN_WIDTH(16), .DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          acc_cycle;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // Reference: saturate to 9999, then split into decimal digits.
  function automatic logic [15:0] model_bcd(input int v);
    int m;
    m = (v > 9999) ? 9999 : v;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("bcd", bcd, e.bcd);
        check("ovf", ovf, e.ovf);
        check("latency", cycle - e.acc_cycle, 17);
        check("busy_at_done", busy, 1'b0);
      end
    end
  end

  task automatic push_exp(input int v);
    exp_t e;
    e.bcd       = model_bcd(v);
    e.ovf       = (v > 9999);
    e.acc_cycle = cycle;
    q.push_back(e);
  endtask

  // Drive one start pulse; the next posedge is the accepting edge.
  task automatic start_conv(input int v);
    bin   = 16'(v);
    start = 1'b1;
    @(posedge clk);
    #1;
    push_exp(v);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vals[$];
    int last_done;

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bcd", bcd, 16'h0000);
    check("rst_ovf", ovf, 1'b0);

    // 1234: busy must be high for exactly 17 cycles, then done with busy low.
    start_conv(1234);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check("busy_during", busy, 1'b1);
      check("done_during", done, 1'b0);
    end
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("bcd_hold", bcd, 16'h1234);

    // Boundaries: zero, largest decimal, add-3 threshold, overflow, recovery.
    vals = '{0, 9999, 5, 10000, 65535, 42};
    foreach (vals[i]) begin
      start_conv(vals[i]);
      wait_done();
    end

    // Second start while busy, with a changed bin, must be ignored.
    start_conv(321);
    repeat (4) @(posedge clk);
    #1;
    bin   = 16'd777;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    repeat (25) @(negedge clk);
    check("ignored_start", q.size(), 0);
    check("bcd_after_ignore", bcd, 16'h0321);

    // start held high: conversions every 18 cycles.
    bin   = 16'd100;
    start = 1'b1;
    last_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 push_exp(100);
      wait_done();
      if (k > 0) check("b2b_period", cycle - last_done, 18);
      last_done = cycle;
    end
    // Next conversion is accepted, then aborted by reset at its 8th cycle.
    @(posedge clk);
    #1 push_exp(100);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    void'(q.pop_back());
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_bcd", bcd, 16'h0000);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_ovf", ovf, 1'b0);
    repeat (25) @(negedge clk);

    // Sweep across the input range plus decimal boundaries.
    vals = '{4, 49, 50, 99, 100, 999, 1000, 9998, 10001, 65534};
    for (int v = 0; v < 65536; v += 37) vals.push_back(v);
    foreach (vals[i]) begin
      start_conv(vals[i]);
      wait_done();
    end

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
